// File: rtl/iq_pair_fifo_pkg.sv
// ============================================================================
// Module   : iq_pair_fifo_pkg
// Brief    : Shared types for the I/Q pair packing stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package iq_pair_fifo_pkg;

  typedef enum logic [0:0] {
    EXP_Q = 1'b0,
    EXP_I = 1'b1
  } pair_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : First-word-fall-through FIFO, 2^PSZ entries, with occupancy level.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int PSZ   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [PSZ:0]     level,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << PSZ;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PSZ:0]     r_wr_ptr;
  logic [PSZ:0]     r_rd_ptr;
  logic             w_pop;
  logic             w_push;

  assign empty    = (r_wr_ptr == r_rd_ptr);
  // Same slot index with differing wrap bits means the writer lapped the reader.
  assign full     = (r_wr_ptr[PSZ] != r_rd_ptr[PSZ]) &&
                    (r_wr_ptr[PSZ-1:0] == r_rd_ptr[PSZ-1:0]);
  assign level    = r_wr_ptr - r_rd_ptr;
  assign pop_data = r_mem[r_rd_ptr[PSZ-1:0]];

  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[PSZ-1:0]] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/iq_pair_fifo.sv
// ============================================================================
// Module   : iq_pair_fifo
// Brief    : Packs interleaved Q/I decimator samples into {I,Q} words, buffers
//            them in a FWFT FIFO and counts overflow / pairing errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iq_pair_fifo
  import iq_pair_fifo_pkg::*;
#(
  parameter int DSZ = 16,
  parameter int PSZ = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear_stats,
  input  logic                  in_valid,
  input  logic signed [DSZ-1:0] in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DSZ-1:0]      out,
  output logic [PSZ:0]          level,
  output logic [15:0]           ovf_count,
  output logic [7:0]            sync_err_count
);

  pair_state_t        r_state;
  logic [DSZ-1:0]     r_q_hold;
  logic [15:0]        r_ovf_count;
  logic [7:0]         r_sync_err_count;
  logic               w_push;
  logic               w_sync_err;
  logic               w_drop;
  logic               w_full;
  logic               w_empty;
  logic [2*DSZ-1:0]   w_word;

  assign w_push     = (r_state == EXP_I) && in_valid;
  assign w_sync_err = (r_state == EXP_I) && !in_valid;
  assign w_word     = {in, r_q_hold};
  // A full FIFO still takes the word when the consumer frees a slot this cycle.
  assign w_drop     = w_push && w_full && !(out_ready && !w_empty);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= EXP_Q;
      r_q_hold <= '0;
    end else begin
      case (r_state)
        EXP_Q: begin
          if (in_valid) begin
            r_q_hold <= in;
            r_state  <= EXP_I;
          end
        end
        EXP_I:   r_state <= EXP_Q;
        default: r_state <= EXP_Q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf_count      <= '0;
      r_sync_err_count <= '0;
    end else if (clear_stats) begin
      r_ovf_count      <= '0;
      r_sync_err_count <= '0;
    end else begin
      if (w_drop && (r_ovf_count != 16'hFFFF))
        r_ovf_count <= r_ovf_count + 16'd1;
      if (w_sync_err && (r_sync_err_count != 8'hFF))
        r_sync_err_count <= r_sync_err_count + 8'd1;
    end
  end

  sync_fifo #(
    .WIDTH (2*DSZ),
    .PSZ   (PSZ)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data (w_word),
    .pop       (out_ready),
    .pop_data  (out),
    .level     (level),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign out_valid      = !w_empty;
  assign ovf_count      = r_ovf_count;
  assign sync_err_count = r_sync_err_count;

endmodule

`default_nettype wire

// File: tb/tb_iq_pair_fifo.sv
// ============================================================================
// Module   : tb_iq_pair_fifo
// Brief    : Scoreboard bench for iq_pair_fifo with directed pair sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iq_pair_fifo;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               clear_stats;
  logic               in_valid;
  logic signed [15:0] in;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out;
  logic [4:0]         level;
  logic [15:0]        ovf_count;
  logic [7:0]         sync_err_count;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  bit          tog = 1'b0;

  iq_pair_fifo #(.DSZ(16), .PSZ(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .clear_stats    (clear_stats),
    .in_valid       (in_valid),
    .in             (in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out            (out),
    .level          (level),
    .ovf_count      (ovf_count),
    .sync_err_count (sync_err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output word is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL out_unexpected: got %h, want none", out);
      end else begin
        check("out_word", out, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (tog) out_ready = ~out_ready;
  endtask

  task automatic send_pair(input logic [15:0] q, input logic [15:0] i, input bit accept);
    in_valid = 1'b1;
    in       = q;
    step();
    in = i;
    if (accept) exp_q.push_back({i, q});
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    out_ready = 1'b1;
    while (level != 0 && cyc < 64) begin
      step();
      cyc++;
    end
    out_ready = 1'b0;
    check("drain_level", 32'(level), 32'd0);
    check("drain_sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset_n     = 1'b0;
    clear_stats = 1'b0;
    in_valid    = 1'b0;
    in          = '0;
    out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf", 32'(ovf_count), 32'd0);
    check("rst_sync", 32'(sync_err_count), 32'd0);
    reset_n = 1'b1;
    step();

    // Single pair
    send_pair(16'h1234, 16'hABCD, 1'b1);
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_out", out, 32'hABCD1234);
    check("t1_level", 32'(level), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t1_level_after_pop", 32'(level), 32'd0);
    check("t1_out_valid_after_pop", 32'(out_valid), 32'd0);

    // Fill past capacity: 17th pair is dropped
    for (int k = 0; k < 17; k++) send_pair(16'(k), 16'(k), k < 16);
    check("t2_level", 32'(level), 32'd16);
    check("t2_ovf", 32'(ovf_count), 32'd1);
    check("t2_sync", 32'(sync_err_count), 32'd0);
    drain();

    // Full with simultaneous pop on the I cycle
    for (int k = 0; k < 16; k++) send_pair(16'(k + 16'h100), 16'(k + 16'h180), 1'b1);
    check("t3_level_full", 32'(level), 32'd16);
    in_valid = 1'b1;
    in       = 16'h0AAA;
    step();
    in        = 16'h0BBB;
    out_ready = 1'b1;
    exp_q.push_back(32'h0BBB0AAA);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("t3_level_kept", 32'(level), 32'd16);
    check("t3_ovf_unchanged", 32'(ovf_count), 32'd1);
    drain();
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    check("clear_ovf", 32'(ovf_count), 32'd0);

    // Broken pair then good pair
    in_valid = 1'b1;
    in       = 16'h7777;
    step();
    in_valid = 1'b0;
    step();
    send_pair(16'h0005, 16'h0006, 1'b1);
    check("t4_sync", 32'(sync_err_count), 32'd1);
    check("t4_level", 32'(level), 32'd1);
    drain();

    // Clear wins over a coinciding sync error
    in_valid = 1'b1;
    in       = 16'h1111;
    step();
    in_valid    = 1'b0;
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    check("clear_wins", 32'(sync_err_count), 32'd0);

    // Wrap with out_ready toggling every cycle
    tog = 1'b1;
    for (int k = 0; k < 40; k++) send_pair(16'(16'h2000 + k), 16'(16'h3000 + k), 1'b1);
    tog = 1'b0;
    check("t5_ovf", 32'(ovf_count), 32'd0);
    drain();

    // Reset mid-operation with FSM waiting for I
    in_valid = 1'b1;
    in       = 16'h4444;
    step();
    in_valid = 1'b0;
    step();
    for (int k = 0; k < 7; k++) send_pair(16'(16'h500 + k), 16'(16'h600 + k), 1'b1);
    check("t6_level_pre", 32'(level), 32'd7);
    check("t6_sync_pre", 32'(sync_err_count), 32'd1);
    in_valid = 1'b1;
    in       = 16'hDEAD;
    step();
    in = 16'hBEEF;
    #2;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    exp_q.delete();
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check("t6_rst_level", 32'(level), 32'd0);
    check("t6_rst_sync", 32'(sync_err_count), 32'd0);
    check("t6_rst_ovf", 32'(ovf_count), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    send_pair(16'h0042, 16'h0099, 1'b1);
    check("t6_level_post", 32'(level), 32'd1);
    check("t6_out_post", out, 32'h00990042);
    drain();
    check("t6_sync_post", 32'(sync_err_count), 32'd0);

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
